// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state
// (IDLE/FETCH) miss handler in front of a single-port memory controller.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state;
  logic [31:0]      miss_addr;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr [SETS];
  logic [31:0]      data_arr [SETS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             fill;
  logic             unused_offset;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];
  // Byte offset within the word carries no information for aligned fetches.
  assign unused_offset = ^imemaddr[1:0];

  assign fill     = (state == FETCH) && !iwait;
  assign ihit     = imemREN && (state == IDLE) && valid[req_idx] &&
                    (tag_arr[req_idx] == req_tag);
  assign imemload = data_arr[req_idx];
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? miss_addr : imemaddr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !ihit) begin
            state     <= FETCH;
            miss_addr <= imemaddr;
          end
        end
        FETCH: begin
          // Fill completes even if the datapath redirected or dropped its request.
          if (!iwait) begin
            state           <= IDLE;
            valid[miss_idx] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[miss_idx]  <= miss_tag;
      data_arr[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus a randomized
// run compared against a line-address reference model.
module tb_icache_direct;

  localparam int SETS  = 16;
  localparam int IDX_W = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks = 0;
  int errors = 0;

  // Reference model: which word address each frame holds, and its data.
  bit          fetching;
  logic [31:0] maddr;
  logic [29:0] m_line [int];
  logic [31:0] m_data [int];

  icache_direct #(.SETS(SETS), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic bit exp_hit();
    return bit'(imemREN && !fetching && m_line.exists(idx_of(imemaddr)) &&
                m_line[idx_of(imemaddr)] == imemaddr[31:2]);
  endfunction

  function automatic logic [31:0] exp_iaddr();
    return fetching ? maddr : imemaddr;
  endfunction

  task automatic model_reset();
    fetching = 1'b0;
    maddr    = '0;
    m_line.delete();
    m_data.delete();
  endtask

  task automatic set_in(input logic ren, input logic [31:0] a, input logic w,
                        input logic [31:0] ld);
    imemREN  = ren;
    imemaddr = a;
    iwait    = w;
    iload    = ld;
  endtask

  task automatic tick();
    bit h;
    h = exp_hit();
    @(posedge CLK);
    if (!nRST) model_reset();
    else if (fetching) begin
      if (!iwait) begin
        m_line[idx_of(maddr)] = maddr[31:2];
        m_data[idx_of(maddr)] = iload;
        fetching = 1'b0;
      end
    end else if (imemREN && !h) begin
      fetching = 1'b1;
      maddr    = imemaddr;
    end
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input int lat, input logic [31:0] d);
    set_in(1'b1, a, 1'b1, 32'h0);
    tick();
    repeat (lat) tick();
    set_in(1'b1, a, 1'b0, d);
    tick();
    set_in(1'b0, a, 1'b1, 32'h0);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    model_reset();
    set_in(1'b1, 32'h0000_1234, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_ihit got=%b exp=0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iREN got=%b exp=0", iREN); end
    checks++; if (iaddr !== 32'h1234) begin errors++; $display("FAIL rst_iaddr got=%h exp=1234", iaddr); end
    tick();
    nRST = 1'b1;
    set_in(1'b0, 32'h0000_0088, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL post_rst_iREN got=%b exp=0", iREN); end
    checks++; if (iaddr !== 32'h88) begin errors++; $display("FAIL post_rst_iaddr got=%h exp=88", iaddr); end
    tick();
  endtask

  task automatic test_cold_miss();
    set_in(1'b1, 32'h40, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_first_ihit got=%b exp=0", ihit); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL cold_fetch_iREN cyc%0d got=%b exp=1", i, iREN); end
      checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL cold_fetch_iaddr cyc%0d got=%h exp=40", i, iaddr); end
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_fetch_ihit cyc%0d got=%b exp=0", i, ihit); end
      tick();
    end
    set_in(1'b1, 32'h40, 1'b0, 32'h2001_0005);
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL cold_last_iREN got=%b exp=1", iREN); end
    tick();
    set_in(1'b1, 32'h40, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL cold_after_ihit got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'h2001_0005) begin errors++; $display("FAIL cold_after_load got=%h exp=20010005", imemload); end
  endtask

  task automatic test_hit();
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL hit_iREN got=%b exp=0", iREN); end
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL hit_ihit got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'h2001_0005) begin errors++; $display("FAIL hit_load got=%h exp=20010005", imemload); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    fill(32'h44, 2, 32'hCAFE_0044);
    set_in(1'b1, 32'h80, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_80_miss got=%b exp=0", ihit); end
    fill(32'h80, 1, 32'hBEEF_0080);
    set_in(1'b1, 32'h80, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL conf_80_hit got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'hBEEF_0080) begin errors++; $display("FAIL conf_80_load got=%h exp=beef0080", imemload); end
    imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_40_evicted got=%b exp=0", ihit); end
    imemaddr = 32'h44;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL conf_44_kept got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'hCAFE_0044) begin errors++; $display("FAIL conf_44_load got=%h exp=cafe0044", imemload); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_redirect();
    set_in(1'b1, 32'h100, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_100_miss got=%b exp=0", ihit); end
    tick();
    set_in(1'b1, 32'h200, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_hold_iaddr got=%h exp=100", iaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_fetch_ihit got=%b exp=0", ihit); end
    tick();
    set_in(1'b1, 32'h200, 1'b0, 32'h1111_0100);
    @(negedge CLK);
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_last_iaddr got=%h exp=100", iaddr); end
    tick();
    set_in(1'b1, 32'h100, 1'b1, 32'h0);
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL redir_100_filled got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'h1111_0100) begin errors++; $display("FAIL redir_100_load got=%h exp=11110100", imemload); end
    imemaddr = 32'h200;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_200_miss got=%b exp=0", ihit); end
    checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL redir_200_iaddr got=%h exp=200", iaddr); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL redir_200_iREN got=%b exp=1", iREN); end
    set_in(1'b0, 32'h200, 1'b0, 32'h2222_0200);
    tick();
    set_in(1'b1, 32'h200, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL noabort_200_hit got=%b exp=1", ihit); end
    checks++; if (imemload !== 32'h2222_0200) begin errors++; $display("FAIL noabort_200_load got=%h exp=22220200", imemload); end
    imemaddr = 32'h100;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_100_evicted got=%b exp=0", ihit); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 32'h300, 1'b1, 32'h0);
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL rmid_fetch_iREN got=%b exp=1", iREN); end
    nRST  = 1'b0;
    iwait = 1'b0;
    iload = 32'hDEAD_0300;
    #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rmid_async_iREN got=%b exp=0", iREN); end
    checks++; if (iaddr !== 32'h300) begin errors++; $display("FAIL rmid_async_iaddr got=%h exp=300", iaddr); end
    tick();
    nRST = 1'b1;
    set_in(1'b1, 32'h300, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmid_300_miss got=%b exp=0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rmid_idle_iREN got=%b exp=0", iREN); end
    imemaddr = 32'h200;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmid_valid_cleared got=%b exp=0", ihit); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] a;
    fill(32'h48, 0, 32'h0A0B_0048);
    set_in(1'b1, 32'h504, 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      a = $urandom() & 32'hFFFF_FFFC;
      set_in(1'($urandom_range(0, 1)), a, 1'b1, $urandom());
      @(negedge CLK);
      checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL stall_iREN cyc%0d got=%b exp=1", i, iREN); end
      checks++; if (iaddr !== 32'h504) begin errors++; $display("FAIL stall_iaddr cyc%0d got=%h exp=504", i, iaddr); end
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL stall_ihit cyc%0d got=%b exp=0", i, ihit); end
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h5555_0504);
    tick();
    set_in(1'b1, 32'h48, 1'b1, 32'h0);
    @(negedge CLK);
    checks++; if (ihit !== 1'b1 || imemload !== 32'h0A0B_0048) begin errors++; $display("FAIL stall_48_kept hit=%b load=%h exp hit=1 load=0a0b0048", ihit, imemload); end
    imemaddr = 32'h504;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'h5555_0504) begin errors++; $display("FAIL stall_504_fill hit=%b load=%h exp hit=1 load=55550504", ihit, imemload); end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          eh;
    for (int i = 0; i < 600; i++) begin
      a = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      set_in(1'($urandom_range(0, 9) < 8), a, 1'($urandom_range(0, 1)), $urandom());
      @(negedge CLK);
      eh = exp_hit();
      checks++; if (ihit !== eh) begin errors++; $display("FAIL rnd_ihit cyc%0d addr=%h got=%b exp=%b", i, imemaddr, ihit, eh); end
      checks++; if (iREN !== fetching) begin errors++; $display("FAIL rnd_iREN cyc%0d got=%b exp=%b", i, iREN, fetching); end
      checks++; if (iaddr !== exp_iaddr()) begin errors++; $display("FAIL rnd_iaddr cyc%0d got=%h exp=%h", i, iaddr, exp_iaddr()); end
      if (eh) begin
        checks++;
        if (imemload !== m_data[idx_of(imemaddr)]) begin
          errors++;
          $display("FAIL rnd_load cyc%0d addr=%h got=%h exp=%h", i, imemaddr, imemload, m_data[idx_of(imemaddr)]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_redirect();
    test_reset_mid();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
